// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: GF(2^8) arithmetic, S-boxes, key schedule step,
// InvMixColumns column transform and the core's state/handshake types.
package aes_pkg;

    typedef logic [127:0]  state_t;
    typedef logic [1407:0] round_keys_t;   // rk0 in the MSBs

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND
    } fsm_t;

    typedef struct packed {
        state_t data;
        state_t key;
    } aes_req_t;

    // RCON[i] is the round constant used to derive round key i+1
    localparam logic [9:0][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                        8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    // S-boxes are computed rather than tabled: inverse followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        logic [7:0] s;
        b = gf_inv(a);
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
        return s ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        for (int i = 0; i < 8; i++)
            b[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8];
        return gf_inv(b ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One key-schedule step: four words of round key r -> round key r+1
    function automatic state_t key_step(input state_t k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Column times the {0e,0b,0d,09} circulant; row 0 is the MSB byte
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes128_decrypt_core_if.sv
// Start/busy/done handshake and data buses of the AES-128 decrypt core.
interface aes128_decrypt_core_if;
    import aes_pkg::*;

    logic   start;
    state_t data_in;
    state_t key_in;
    logic   busy;
    logic   done;
    state_t data_out;

    modport master (output start, data_in, key_in, input busy, done, data_out);
    modport slave  (input start, data_in, key_in, output busy, done, data_out);
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when is_last).
module aes_inv_round
    import aes_pkg::*;
(
    input  state_t st_in,
    input  state_t rk,
    input  logic   is_last,
    output state_t st_out
);
    localparam int NUM_COLS = 4;

    state_t pre;

    // byte n sits at row n%4, column n/4; row r rotates right by r columns
    for (genvar n = 0; n < 16; n++) begin : g_byte
        localparam int ROW = n % 4;
        localparam int COL = n / 4;
        localparam int SRC = ((COL + 4 - ROW) % 4) * 4 + ROW;
        assign pre[127-8*n -: 8] = inv_sbox(st_in[127-8*SRC -: 8]) ^ rk[127-8*n -: 8];
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        logic [31:0] col;
        assign col = pre[127-32*c -: 32];
        assign st_out[127-32*c -: 32] = is_last ? col : inv_mix_col(col);
    end
endmodule

// File: rtl/aes128_decrypt_core.sv
// Iterative AES-128 inverse cipher: one AddRoundKey/round step per clock,
// round keys expanded combinationally from the latched cipher key.
module aes128_decrypt_core
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input logic                  clk,
    input logic                  rst_n,
    aes128_decrypt_core_if.slave bus
);
    localparam int KW = NK * 32;

    fsm_t              fsm, fsm_nxt;
    state_t            st;
    logic [KW-1:0]     key_reg;
    state_t            dout;
    logic [3:0]        rnd;
    logic              busy, done;
    logic              accept, last;
    aes_req_t          req;
    round_keys_t       rk_bus;
    logic [10:0][127:0] rk_arr;
    state_t            rnd_out;

    assign req = '{data: bus.data_in, key: bus.key_in};

    // Key schedule chain: each stage derives the next round key from the previous one
    for (genvar r = 0; r <= 10; r++) begin : g_rk
        state_t k;
        if (r == 0) begin : g_base
            assign k = key_reg;
        end else begin : g_step
            assign k = key_step(g_rk[r-1].k, RCON[r-1]);
        end
        assign rk_bus[(11-r)*128-1 -: 128] = k;
        assign rk_arr[r] = rk_bus[(11-r)*128-1 -: 128];
    end

    aes_inv_round u_round (
        .st_in   (st),
        .rk      (rk_arr[rnd]),
        .is_last (rnd == 4'd0),
        .st_out  (rnd_out)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= S_IDLE;
        else        fsm <= fsm_nxt;
    end

    // Next state; start is only looked at in IDLE, which is exactly when busy=0
    always_comb begin
        fsm_nxt = fsm;
        accept  = 1'b0;
        last    = 1'b0;
        case (fsm)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    fsm_nxt = S_LOAD;
                end
            end
            S_LOAD:  fsm_nxt = S_ROUND;
            S_ROUND: begin
                if (rnd == 4'd0) begin
                    last    = 1'b1;
                    fsm_nxt = S_IDLE;
                end
            end
            default: fsm_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch request, initial AddRoundKey with rk10, then rounds rnd=9..0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= '0;
            key_reg <= '0;
            dout    <= '0;
            rnd     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                key_reg <= req.key;
                st      <= req.data;
                busy    <= 1'b1;
            end else if (fsm == S_LOAD) begin
                st  <= st ^ rk_arr[10];
                rnd <= 4'(NR - 1);
            end else if (fsm == S_ROUND) begin
                st <= rnd_out;
                if (last) begin
                    dout <= rnd_out;
                    done <= 1'b1;
                    busy <= 1'b0;
                end else begin
                    rnd <= rnd - 4'd1;
                end
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.data_out = dout;
endmodule

// File: tb/tb_aes128_decrypt_core.sv
// Self-checking bench for aes128_decrypt_core. Reference: a forward AES-128
// encryptor built from table lookups (S-box found by brute-force inversion),
// so random plaintexts are encrypted here and must come back from the DUT.
module tb_aes128_decrypt_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    aes128_decrypt_core_if bus();

    aes128_decrypt_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb [256];

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        logic [127:0] rk10;
        bit           chk_rk;
    } vec_t;

    vec_t vecs [3];

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        logic [7:0] y;
        r = 8'h00; x = a; y = b;
        while (y != 8'h00) begin
            if (y[0]) r = r ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk;
        logic [7:0]   a0, a1, a2, a3;
        rk = round_key(key, 0);
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ rk[127-8*n -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            // SubBytes + ShiftRows (row r rotates left by r)
            for (int n = 0; n < 16; n++) t[n] = sb[s[(((n / 4) + (n % 4)) % 4) * 4 + (n % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            rk = round_key(key, rnd);
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[127-8*n -: 8];
        end
        for (int n = 0; n < 16; n++) pt[127-8*n -: 8] = s[n];
        return pt;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one block and wait (bounded) for done; lat counts edges after the accepting one
    task automatic do_block(input logic [127:0] ct, input logic [127:0] key,
                            output int lat, output logic [127:0] res,
                            output logic busy0, output logic [127:0] rk10);
        bus.start = 1'b1; bus.data_in = ct; bus.key_in = key;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy0 = bus.busy;
        rk10  = dut.rk_bus[127:0];
        lat = 0;
        while (!bus.done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.data_out;
    endtask

    initial begin
        int           lat, t1, t2;
        logic [127:0] res, rk10, p1, p2, k1, k2, c1, c2, held;
        logic         busy0, seen;

        bus.start = 1'b0; bus.data_in = '0; bus.key_in = '0;
        build_sbox();

        vecs[0] = '{"fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff,
                    128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1};
        vecs[1] = '{"zero", 128'h0,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    128'h0, 128'h0, 1'b0};
        vecs[2] = '{"fips_a1", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_dout", bus.data_out, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("model_c1", encrypt(vecs[0].pt, vecs[0].key), vecs[0].ct);

        // known-answer vectors
        for (int i = 0; i < 3; i++) begin
            do_block(vecs[i].ct, vecs[i].key, lat, res, busy0, rk10);
            chk({vecs[i].name, "_busy"}, busy0, 1);
            if (vecs[i].chk_rk) chk({vecs[i].name, "_rk10"}, rk10, vecs[i].rk10);
            chk({vecs[i].name, "_lat"}, lat, 11);
            chk({vecs[i].name, "_pt"}, res, vecs[i].pt);
            @(posedge clk); #1;
            chk({vecs[i].name, "_done_fall"}, bus.done, 0);
            chk({vecs[i].name, "_busy_idle"}, bus.busy, 0);
        end

        // hold: inputs wiggle without start
        held = bus.data_out;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.data_in = rand128(); bus.key_in = rand128();
            @(posedge clk); #1;
            seen |= bus.done;
        end
        chk("hold_dout", bus.data_out, held);
        chk("hold_done", seen, 0);

        // start while busy is ignored
        bus.start = 1'b1; bus.data_in = vecs[0].ct; bus.key_in = vecs[0].key;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        repeat (4) begin @(posedge clk); #1; lat++; end
        bus.start = 1'b1; bus.data_in = vecs[2].ct; bus.key_in = vecs[2].key;
        @(posedge clk); #1; lat++;
        bus.start = 1'b0;
        while (!bus.done && lat < 30) begin @(posedge clk); #1; lat++; end
        chk("busy_ign_lat", lat, 11);
        chk("busy_ign_pt", bus.data_out, vecs[0].pt);
        @(posedge clk); #1;
        chk("busy_ign_idle", bus.busy, 0);

        // back-to-back with start held high
        p1 = rand128(); k1 = rand128(); c1 = encrypt(p1, k1);
        p2 = rand128(); k2 = rand128(); c2 = encrypt(p2, k2);
        bus.start = 1'b1; bus.data_in = c1; bus.key_in = k1;
        @(posedge clk); #1;
        bus.data_in = c2; bus.key_in = k2;
        t1 = -1; t2 = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                if (t1 < 0) begin
                    t1 = i;
                    chk("b2b_pt1", bus.data_out, p1);
                end else if (t2 < 0) begin
                    t2 = i;
                    chk("b2b_pt2", bus.data_out, p2);
                end
            end
            if (i == 12) begin
                chk("b2b_second_accept", bus.busy, 1);
                bus.start = 1'b0;
            end
        end
        chk("b2b_t1", t1, 11);
        chk("b2b_gap", t2 - t1, 12);

        // reset mid-operation
        p1 = rand128(); k1 = rand128(); c1 = encrypt(p1, k1);
        bus.start = 1'b1; bus.data_in = c1; bus.key_in = k1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_done", bus.done, 0);
        chk("rst_mid_dout", bus.data_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin @(posedge clk); #1; seen |= bus.done; end
        chk("rst_mid_no_done", seen, 0);
        do_block(c1, k1, lat, res, busy0, rk10);
        chk("rst_after_lat", lat, 11);
        chk("rst_after_pt", res, p1);

        // randomized blocks against the forward model
        for (int i = 0; i < 8; i++) begin
            p1 = rand128(); k1 = rand128(); c1 = encrypt(p1, k1);
            do_block(c1, k1, lat, res, busy0, rk10);
            chk($sformatf("rand%0d_rk10", i), rk10, round_key(k1, 10));
            chk($sformatf("rand%0d_lat", i), lat, 11);
            chk($sformatf("rand%0d_pt", i), res, p1);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes128_decrypt_core.md
Name: aes128_decrypt_core

Overview:
Iterative AES-128 inverse cipher (FIPS-197) with built-in key expansion. It latches a 128-bit ciphertext and cipher key, expands the key into 11 round keys, then runs the initial AddRoundKey, 9 full inverse rounds and 1 final inverse round, one step per clock. It sits in the crypto datapath as the decrypt engine and uses a simple start/busy/done handshake.

Parameters:
NK, 4, key length in 32-bit words; only 4 is supported.
NR, 10, number of rounds; only 10 is supported.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled on the rising edge, accepted only when busy=0.
data_in  in  128  ciphertext; byte 0 = bits[127:120]; state is column-major (byte n → row n%4, column n/4).
key_in  in  128  cipher key, same byte order.
busy  out  1  high from the accepting edge until the done edge.
done  out  1  one-cycle pulse; data_out is valid in that cycle.
data_out  out  128  plaintext; holds its value until the next completion.

Behaviour:
- Reset (async, rst_n=0): state, key_reg, data_out, round counter = 0; busy=0; done=0; FSM = IDLE. Reset mid-operation aborts the operation with no done pulse.
- Key expansion: combinational from the registered key_reg, per FIPS-197 §5.2.
  - w[i] = w[i-4] ^ (i%4==0 ? SubWord(RotWord(w[i-1])) ^ Rcon[i/4] : w[i-1]).
  - Rcon = 01,02,04,08,10,20,40,80,1b,36 in the MSB of the word.
  - Round key rk_r = w[4r..4r+3]. On the packed 1408-bit bus, rk0 is in the MSBs: rk_r = bus[(11-r)*128-1 -: 128].
- FSM IDLE → LOAD → ROUND → IDLE:
  - E0, edge with start=1 and busy=0: key_reg ← key_in; state ← data_in; busy ← 1; go to LOAD.
  - E1: state ← state ^ rk10; rnd ← 9; go to ROUND.
  - E2..E10, rnd = 9..1: state ← InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_rnd)); rnd decrements.
  - E11, rnd = 0: final round state ← AddRoundKey(InvSubBytes(InvShiftRows(state)), rk0), with no InvMixColumns. Same edge: data_out ← result; done ← 1; busy ← 0; go to IDLE.
  - done falls on the next edge.
- Latency: done is high in the cycle after E11, i.e. 11 clocks after the accepting edge. Throughput: one block per 12 cycles.
- start while busy=1 is ignored and not queued. start in the done cycle is accepted, since busy=0 then.
- data_in and key_in are don't-care except on the accepting edge.
- InvShiftRows: row r rotates right by r bytes.
- InvMixColumns: matrix {0e,0b,0d,09} circulant over GF(2^8), reduction polynomial 0x11b.

Decomposition:
- Shared package aes_pkg:
  - forward S-box function (used by key expansion) and inverse S-box function;
  - xtime and gf_mul helpers;
  - Rcon constant array;
  - typedefs state_t (128-bit) and round_keys_t (11×128).
- One natural sub-module: aes_inv_round, a purely combinational block. Inputs: state, round key, is_last flag (skips InvMixColumns). Output: the new state.
- Key expansion and the initial AddRoundKey stay inline in aes128_decrypt_core.

Test Plan:
- FIPS C.1: key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a, start → done 11 cycles later, data_out = 00112233445566778899aabbccddeeff; internal rk10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Zero vector: key 0, data_in 66e94bd4ef8a2c3b884cfa59ca342b2e → data_out = 0. Then FIPS A.1 key 2b7e151628aed2a6abf7158809cf4f3c → rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Busy rule: start re-pulsed with different data at cycle 5 of an operation → ignored; result and timing match the first request exactly.
- Back-to-back: start held high continuously → second block accepted in the done cycle; two done pulses 12 cycles apart with correct results for each.
- Reset mid-op: rst_n low at cycle 6 → busy=0, done=0, data_out=0 immediately, no done pulse. After release, a new start produces the correct result.
- Hold: after done, change data_in and key_in without start → data_out unchanged, done stays 0.
